// File: rtl/poseidon_stream_driver.sv
// Programmable beat-buffer stream driver with packet framing, looping and early stop,
// plus an output-stream capture side with counters and an optional ready toggle pattern.
module poseidon_stream_driver #(
  parameter int DATA_W = 255,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW:0]       cfg_beats,
  input  logic [7:0]        cfg_pkt_len,
  input  logic              cfg_loop,
  input  logic              cfg_stall,
  input  logic              start,
  input  logic              stop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] m_payload,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [DATA_W-1:0] s_payload,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tx_beats,
  output logic [15:0]       rx_beats,
  output logic [15:0]       rx_pkts,
  output logic [DATA_W-1:0] rx_last_payload
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [AW:0] BEATS_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [7:0]    pkt_cnt, pkt_cnt_nxt;
  logic [7:0]    pkt_len_q;
  logic [AW:0]   beats_q;
  logic          loop_q;
  logic          stop_pend, stop_pend_nxt;
  logic          done_nxt;
  logic          launch;
  logic          hs, last_beat, stop_req;

  // Outputs derive only from registered state, so they hold steady while stalled.
  assign m_valid   = (state == SEND);
  assign busy      = m_valid;
  assign hs        = m_valid & m_ready;
  assign last_beat = ({1'b0, idx} == (beats_q - BEATS_ONE));
  assign m_last    = m_valid & ((pkt_cnt == (pkt_len_q - 8'd1)) | last_beat);
  assign m_payload = m_valid ? mem[idx] : '0;
  assign stop_req  = stop_pend | stop;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pkt_cnt   <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      pkt_cnt   <= pkt_cnt_nxt;
      stop_pend <= stop_pend_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    pkt_cnt_nxt   = pkt_cnt;
    stop_pend_nxt = stop_req;
    done_nxt      = 1'b0;
    launch        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // A stop arriving alongside start is dropped.
          stop_pend_nxt = 1'b0;
          launch        = 1'b1;
          idx_nxt       = '0;
          pkt_cnt_nxt   = '0;
          if (cfg_beats != '0) state_nxt = SEND;
          else                 done_nxt  = 1'b1;
        end
      end
      SEND: begin
        if (hs) begin
          if ((m_last && stop_req) || (last_beat && !loop_q)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
          idx_nxt     = last_beat ? '0 : idx + AW'(1);
          pkt_cnt_nxt = m_last ? 8'd0 : pkt_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beats_q   <= '0;
      pkt_len_q <= 8'd1;
      loop_q    <= 1'b0;
    end else if (launch) begin
      beats_q   <= cfg_beats;
      pkt_len_q <= (cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len;
      loop_q    <= cfg_loop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_beats        <= '0;
      rx_beats        <= '0;
      rx_pkts         <= '0;
      rx_last_payload <= '0;
      s_ready         <= 1'b0;
    end else begin
      s_ready <= cfg_stall ? ~s_ready : 1'b1;
      if (launch) begin
        tx_beats <= '0;
        rx_beats <= '0;
        rx_pkts  <= '0;
      end else begin
        if (hs && tx_beats != 16'hFFFF) tx_beats <= tx_beats + 16'd1;
        if (s_valid && s_ready) begin
          if (rx_beats != 16'hFFFF)           rx_beats <= rx_beats + 16'd1;
          if (s_last && rx_pkts != 16'hFFFF) rx_pkts  <= rx_pkts + 16'd1;
        end
      end
      if (s_valid && s_ready) rx_last_payload <= s_payload;
    end
  end

endmodule

// File: tb/tb_poseidon_stream_driver.sv
// Randomized self-checking bench for poseidon_stream_driver against a beat-list reference model.
module tb_poseidon_stream_driver;
  localparam int DATA_W = 255;
  localparam int DEPTH  = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [AW:0]       cfg_beats = '0;
  logic [7:0]        cfg_pkt_len = '0;
  logic              cfg_loop = 1'b0;
  logic              cfg_stall = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              m_ready_drv = 1'b0;
  logic              lb = 1'b0;
  logic              m_valid, m_last, s_ready, busy, done;
  logic [DATA_W-1:0] m_payload, rx_last_payload;
  logic [15:0]       tx_beats, rx_beats, rx_pkts;
  wire               m_ready_w   = lb ? s_ready : m_ready_drv;
  wire               s_valid_w   = lb ? m_valid : 1'b0;
  wire               s_last_w    = lb & m_last;
  wire  [DATA_W-1:0] s_payload_w = lb ? m_payload : '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] got_pay[$];
  bit                got_last[$];
  int                hs_cyc[$];
  int                done_cyc, stab_err, sr_err;
  bit                timeout;

  always #5 clk = ~clk;

  poseidon_stream_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_beats(cfg_beats), .cfg_pkt_len(cfg_pkt_len), .cfg_loop(cfg_loop), .cfg_stall(cfg_stall),
    .start(start), .stop(stop),
    .m_valid(m_valid), .m_ready(m_ready_w), .m_last(m_last), .m_payload(m_payload),
    .s_valid(s_valid_w), .s_ready(s_ready), .s_last(s_last_w), .s_payload(s_payload_w),
    .busy(busy), .done(done), .tx_beats(tx_beats), .rx_beats(rx_beats), .rx_pkts(rx_pkts),
    .rx_last_payload(rx_last_payload)
  );

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // Beat n of a stream: packets restart at every pass boundary.
  function automatic bit exp_last(int n, int b, int lraw);
    int l = (lraw == 0) ? 1 : lraw;
    int k = n % b;
    return ((k % l) == l - 1) || (k == b - 1);
  endfunction

  task automatic load(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; mem_model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int b, input int l, input bit lp);
    cfg_beats = (AW+1)'(b); cfg_pkt_len = 8'(l); cfg_loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records accepted beats until done; tracks hold-while-stalled and s_ready toggle violations.
  task automatic collect(input int max_cyc, input bit rnd, input int stop_beat);
    logic [DATA_W-1:0] prev_pay;
    bit prev_last, pend, prev_sr;
    got_pay.delete(); got_last.delete(); hs_cyc.delete();
    done_cyc = -1; stab_err = 0; sr_err = 0; timeout = 1; pend = 0; prev_sr = 0;
    prev_pay = '0; prev_last = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin done_cyc = c; timeout = 0; break; end
      m_ready_drv = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      stop = 1'b0;
      if (stop_beat == got_pay.size() && m_valid) begin stop = 1'b1; m_ready_drv = 1'b1; end
      #1;
      if (c > 0 && cfg_stall && s_ready == prev_sr) sr_err++;
      prev_sr = s_ready;
      if (pend && (m_valid !== 1'b1 || m_payload !== prev_pay || m_last !== prev_last)) stab_err++;
      if (m_valid && m_ready_w) begin
        got_pay.push_back(m_payload); got_last.push_back(m_last); hs_cyc.push_back(c); pend = 0;
      end else begin
        pend = m_valid; prev_pay = m_payload; prev_last = m_last;
      end
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  // Compares the collected stream with the model for a pass of b beats and packet length l.
  task automatic check_stream(input string nm, input int nexp, input int b, input int l);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL %s timeout: done never seen", nm); end
    n_checks++;
    if (got_pay.size() != nexp) begin
      n_fail++; $display("FAIL %s beat count: got %0d want %0d", nm, got_pay.size(), nexp);
    end
    for (int n = 0; n < got_pay.size() && n < nexp; n++) begin
      n_checks++;
      if (got_pay[n] !== mem_model[n % b] || got_last[n] !== exp_last(n, b, l)) begin
        n_fail++;
        $display("FAIL %s beat %0d: got pay=%h last=%0b want pay=%h last=%0b", nm, n,
                 got_pay[n], got_last[n], mem_model[n % b], exp_last(n, b, l));
      end
    end
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL %s stability: %0d violations want 0", nm, stab_err); end
    if (hs_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc != hs_cyc[hs_cyc.size()-1] + 1) begin
        n_fail++; $display("FAIL %s done timing: cycle %0d want %0d", nm, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
      end
    end
    n_checks++;
    if (tx_beats !== 16'(nexp) || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s tx_beats/busy: got %0d/%0b want %0d/0", nm, tx_beats, busy, nexp);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL %s done pulse width: done=%0b want 0", nm, done); end
  endtask

  task automatic test_reset();
    cfg_stall = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset s_ready: got %0b want 0", s_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_last, busy, done, tx_beats, rx_beats, rx_pkts} !== '0 || m_payload !== '0 || rx_last_payload !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: v=%0b l=%0b busy=%0b done=%0b tx=%0d rx=%0d pk=%0d want all 0",
               m_valid, m_last, busy, done, tx_beats, rx_beats, rx_pkts);
    end
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset s_ready first: got %0b want 1", s_ready); end
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset s_ready toggle: got %0b want 0", s_ready); end
    cfg_stall = 1'b0;
  endtask

  task automatic test_basic_30();
    for (int i = 0; i < DEPTH; i++) load(i, DATA_W'(i));
    do_start(30, 3, 0);
    n_checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic start latency: valid=%0b busy=%0b want 1/1", m_valid, busy);
    end
    collect(200, 0, -1);
    for (int n = 0; n < hs_cyc.size(); n++) begin
      n_checks++;
      if (hs_cyc[n] != n) begin n_fail++; $display("FAIL basic throughput beat %0d: cycle %0d want %0d", n, hs_cyc[n], n); end
    end
    check_stream("basic30", 30, 30, 3);
  endtask

  task automatic test_random_ready();
    do_start(7, 3, 0);
    collect(300, 1, -1);
    check_stream("rand_ready", 7, 7, 3);
  endtask

  task automatic test_loop_stop();
    int nexp = 9;
    while (!exp_last(nexp, 4, 2)) nexp++;
    nexp++;
    do_start(4, 2, 1);
    collect(300, 0, 9);
    check_stream("loop_stop", nexp, 4, 2);
  endtask

  task automatic test_loopback();
    cfg_stall = 1'b1; lb = 1'b1;
    do_start(6, 3, 0);
    collect(300, 0, -1);
    n_checks++;
    if (sr_err != 0) begin n_fail++; $display("FAIL loopback s_ready pattern: %0d repeats want 0", sr_err); end
    n_checks++;
    if (rx_beats !== 16'd6 || rx_pkts !== 16'd2 || rx_last_payload !== mem_model[5]) begin
      n_fail++; $display("FAIL loopback capture: rx=%0d pkts=%0d last=%h want 6/2/%h", rx_beats, rx_pkts, rx_last_payload, mem_model[5]);
    end
    check_stream("loopback", 6, 6, 3);
    lb = 1'b0; cfg_stall = 1'b0;
  endtask

  task automatic test_write_during_send();
    for (int i = 0; i < 16; i++) load(i, rnd_word());
    m_ready_drv = 1'b0;
    do_start(16, 4, 0);
    wr_en = 1'b1; wr_addr = AW'(8); wr_data = ~mem_model[8];
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    collect(200, 0, -1);
    check_stream("wr_during_send", 16, 16, 4);
  endtask

  task automatic test_random_cfg();
    for (int r = 0; r < 4; r++) begin
      int b = $urandom_range(1, DEPTH);
      int l = $urandom_range(0, 5);
      for (int i = 0; i < b; i++) load(i, rnd_word());
      do_start(b, l, 0);
      collect(1000, 1, -1);
      check_stream("random_cfg", b, b, l);
    end
  endtask

  task automatic test_zero_and_reset();
    bit bad_done, bad_valid;
    m_ready_drv = 1'b1;
    do_start(0, 3, 0);
    n_checks++;
    if (done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero beats: done=%0b valid=%0b busy=%0b want 1/0/0", done, m_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero beats after: done=%0b valid=%0b want 0/0", done, m_valid);
    end
    for (int i = 0; i < 10; i++) load(i, DATA_W'(i + 100));
    do_start(10, 3, 0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (m_payload !== mem_model[4]) begin n_fail++; $display("FAIL midreset beat4: got %h want %h", m_payload, mem_model[4]); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_last, busy, done, s_ready, tx_beats, rx_beats, rx_pkts} !== '0 || m_payload !== '0) begin
      n_fail++; $display("FAIL midreset outputs: v=%0b busy=%0b done=%0b tx=%0d want all 0", m_valid, busy, done, tx_beats);
    end
    reset = 1'b0;
    bad_done = 0; bad_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) bad_done = 1;
      if (m_valid) bad_valid = 1;
    end
    n_checks++;
    if (bad_done || bad_valid) begin
      n_fail++; $display("FAIL midreset aftermath: done seen=%0b valid seen=%0b want 0/0", bad_done, bad_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_30();
    test_random_ready();
    test_loop_stop();
    test_loopback();
    test_write_during_send();
    test_random_cfg();
    test_zero_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
